// File: rtl/pick_pkg.sv
// Shared types, screen code and geometry defaults for the colour-picker front end.
package pick_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAG_LIN,
    DRAG_LR,
    ARM_CLOSE
  } pick_state_t;

  localparam logic [2:0] SCREEN_PICKER = 3'b001;

  localparam int unsigned DEF_CENTER_X = 320;
  localparam int unsigned DEF_CENTER_Y = 240;
  localparam int unsigned DEF_RADIUS   = 100;
  localparam int unsigned DEF_HIT      = 8;
  localparam int unsigned DEF_CLOSE_X  = 500;
  localparam int unsigned DEF_CLOSE_Y  = 100;
  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;

  // Square box test: both axis distances within half.
  function automatic logic in_box(coord_t ax, coord_t ay, coord_t bx, coord_t by, coord_t half);
    coord_t dx;
    coord_t dy;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    return (dx <= half) && (dy <= half);
  endfunction

endpackage

// File: rtl/pick_controller_if.sv
// Mouse packet bus: one-cycle valid strobe carrying signed deltas and the left button level.
interface pick_controller_if;

  logic       mouse_valid;
  logic [8:0] mouse_dx;
  logic [8:0] mouse_dy;
  logic       mouse_btn;

  modport master (
    output mouse_valid,
    output mouse_dx,
    output mouse_dy,
    output mouse_btn
  );

  modport slave (
    input mouse_valid,
    input mouse_dx,
    input mouse_dy,
    input mouse_btn
  );

endinterface

// File: rtl/pick_clamp.sv
// Saturating add of a signed 9-bit delta to a 10-bit coordinate, clamped to [LO, HI].
// With a zero delta it is a plain range clamp.
module pick_clamp
  import pick_pkg::*;
#(
  parameter int unsigned LO = 0,
  parameter int unsigned HI = 1023
) (
  input  coord_t            coord,
  input  logic signed [8:0] delta,
  output coord_t            result
);

  // 12-bit signed holds every coord + delta sum without wrap.
  localparam logic signed [11:0] LoS = 12'(LO);
  localparam logic signed [11:0] HiS = 12'(HI);
  localparam coord_t             LoC = coord_t'(LO);
  localparam coord_t             HiC = coord_t'(HI);

  logic signed [11:0] sum;

  assign sum = $signed({2'b00, coord}) + $signed({{3{delta[8]}}, delta});

  // Saturate the sum into the allowed window.
  always_comb begin
    result = sum[9:0];
    if (sum < LoS) begin
      result = LoC;
    end else if (sum > HiS) begin
      result = HiC;
    end
  end

endmodule

// File: rtl/pick_controller.sv
// Colour-picker front end: tracks a mouse cursor, runs the handle drag FSM and presents
// handle positions from frame-synchronous shadow registers.
// Optional build macro PICK_SNAP_EN: on drag release the handle snaps to a multiple of 4.
module pick_controller
  import pick_pkg::*;
#(
  parameter int unsigned CENTER_X = DEF_CENTER_X,
  parameter int unsigned CENTER_Y = DEF_CENTER_Y,
  parameter int unsigned RADIUS   = DEF_RADIUS,
  parameter int unsigned HIT      = DEF_HIT,
  parameter int unsigned CLOSE_X  = DEF_CLOSE_X,
  parameter int unsigned CLOSE_Y  = DEF_CLOSE_Y,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic [2:0]              currScreen,
  pick_controller_if.slave        mouse,
  output coord_t                  CursorX,
  output coord_t                  CursorY,
  output coord_t                  PickX,
  output coord_t                  PickY,
  output coord_t                  pickLRx,
  output coord_t                  pickLRy,
  output logic                    close,
  output logic                    close_req,
  output logic                    dragging
);

  localparam coord_t CX     = coord_t'(CENTER_X);
  localparam coord_t CY     = coord_t'(CENTER_Y);
  localparam coord_t HALF   = coord_t'(HIT);
  localparam coord_t CLX    = coord_t'(CLOSE_X);
  localparam coord_t CLY    = coord_t'(CLOSE_Y);

  coord_t      cur_x;
  coord_t      cur_y;
  coord_t      new_x;
  coord_t      new_y;
  coord_t      lin_y;
  coord_t      lr_x;
  coord_t      lin_rel;
  coord_t      lr_rel;
  coord_t      shadow_y;
  coord_t      shadow_lrx;
  coord_t      pick_y;
  coord_t      pick_lrx;
  pick_state_t state;
  logic        btn_prev;
  logic        close_q;
  logic        close_req_q;
  logic        live;
  logic        press;
  logic        rel;
  logic        hit_lin;
  logic        hit_lr;
  logic        hit_close;
  logic        hit_close_new;

  assign live  = (currScreen == SCREEN_PICKER);
  assign press = mouse.mouse_valid & mouse.mouse_btn & ~btn_prev;
  assign rel   = mouse.mouse_valid & ~mouse.mouse_btn & btn_prev;

  // Next cursor position, saturated to the screen.
  pick_clamp #(
    .LO(0),
    .HI(SCREEN_W - 1)
  ) u_clamp_x (
    .coord (cur_x),
    .delta (mouse.mouse_dx),
    .result(new_x)
  );

  pick_clamp #(
    .LO(0),
    .HI(SCREEN_H - 1)
  ) u_clamp_y (
    .coord (cur_y),
    .delta (mouse.mouse_dy),
    .result(new_y)
  );

  // Handle positions follow the new cursor, limited to their tracks.
  pick_clamp #(
    .LO(CENTER_Y - RADIUS),
    .HI(CENTER_Y + RADIUS)
  ) u_clamp_lin (
    .coord (new_y),
    .delta (9'sd0),
    .result(lin_y)
  );

  pick_clamp #(
    .LO(CENTER_X - RADIUS),
    .HI(CENTER_X + RADIUS)
  ) u_clamp_lr (
    .coord (new_x),
    .delta (9'sd0),
    .result(lr_x)
  );

`ifdef PICK_SNAP_EN
  coord_t lin_snap_raw;
  coord_t lr_snap_raw;

  // Round half up to a multiple of 4, then keep it on the track.
  assign lin_snap_raw = (lin_y + 10'd2) & ~10'd3;
  assign lr_snap_raw  = (lr_x + 10'd2) & ~10'd3;

  pick_clamp #(
    .LO(CENTER_Y - RADIUS),
    .HI(CENTER_Y + RADIUS)
  ) u_snap_lin (
    .coord (lin_snap_raw),
    .delta (9'sd0),
    .result(lin_rel)
  );

  pick_clamp #(
    .LO(CENTER_X - RADIUS),
    .HI(CENTER_X + RADIUS)
  ) u_snap_lr (
    .coord (lr_snap_raw),
    .delta (9'sd0),
    .result(lr_rel)
  );
`else
  assign lin_rel = lin_y;
  assign lr_rel  = lr_x;
`endif

  // Grab tests look at the cursor as registered before this packet.
  assign hit_lin       = in_box(cur_x, cur_y, CX, shadow_y, HALF);
  assign hit_lr        = in_box(cur_x, cur_y, shadow_lrx, CY, HALF);
  assign hit_close     = in_box(cur_x, cur_y, CLX, CLY, HALF);
  assign hit_close_new = in_box(new_x, new_y, CLX, CLY, HALF);

  // Cursor tracking and registered close hover flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cur_x   <= CX;
      cur_y   <= CY;
      close_q <= 1'b0;
    end else begin
      if (mouse.mouse_valid) begin
        cur_x <= new_x;
        cur_y <= new_y;
      end
      close_q <= hit_close & live;
    end
  end

  // Drag FSM, shadow handles, frame-synchronous output copy and close request pulse.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      btn_prev    <= 1'b0;
      shadow_y    <= CY;
      shadow_lrx  <= CX;
      pick_y      <= CY;
      pick_lrx    <= CX;
      close_req_q <= 1'b0;
    end else begin
      close_req_q <= 1'b0;
      if (mouse.mouse_valid) begin
        btn_prev <= mouse.mouse_btn;
      end
      // Copy takes the pre-packet shadow; a coincident packet shows at the next tick.
      if (frame_tick) begin
        pick_y   <= shadow_y;
        pick_lrx <= shadow_lrx;
      end
      if (!live) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (press) begin
              if (hit_lin) begin
                state <= DRAG_LIN;
              end else if (hit_lr) begin
                state <= DRAG_LR;
              end else if (hit_close) begin
                state <= ARM_CLOSE;
              end
            end
          end
          DRAG_LIN: begin
            if (mouse.mouse_valid) begin
              shadow_y <= rel ? lin_rel : lin_y;
              if (rel) begin
                state <= IDLE;
              end
            end
          end
          DRAG_LR: begin
            if (mouse.mouse_valid) begin
              shadow_lrx <= rel ? lr_rel : lr_x;
              if (rel) begin
                state <= IDLE;
              end
            end
          end
          ARM_CLOSE: begin
            if (rel) begin
              close_req_q <= hit_close_new;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign CursorX   = cur_x;
  assign CursorY   = cur_y;
  assign PickX     = CX;
  assign PickY     = pick_y;
  assign pickLRx   = pick_lrx;
  assign pickLRy   = CY;
  assign close     = close_q;
  assign close_req = close_req_q;
  assign dragging  = (state == DRAG_LIN) || (state == DRAG_LR);

endmodule
